// File: rtl/adder_stage_ctrl_if.sv
// Operand/result handshake bundle between the sequencing stage, its upstream,
// downstream, and the combinational adder it drives.
interface adder_stage_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH:0]   add_sum;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   out_sum;

   // master: upstream/downstream/adder side
   modport master (
      output in_valid, in_a, in_b, out_ready, add_sum,
      input  in_ready, out_valid, out_sum, add_a, add_b
   );

   // slave: the sequencing stage itself
   modport slave (
      input  in_valid, in_a, in_b, out_ready, add_sum,
      output in_ready, out_valid, out_sum, add_a, add_b
   );
endinterface

// File: rtl/adder_stage_ctrl.sv
// Sequencing stage ahead of a combinational carry-skip adder: holds operands,
// waits a settle window, captures SUM. Optional self-check: ADDER_CHECK_EN.
module adder_stage_ctrl #(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   adder_stage_ctrl_if.slave   bus,
   output logic                busy,
   output logic                err
);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH:0]   sum_q, sum_d;
   logic             valid_q, valid_d;
   logic             ready_c;
   logic             accept;
   logic             capture;

   assign ready_c       = (state == IDLE) | ((state == HOLD) & bus.out_ready);
   assign accept        = bus.in_valid & ready_c;
   assign capture       = (state == SETTLE) & (cnt == '0);
   assign bus.in_ready  = ready_c;
   assign bus.add_a     = a_q;
   assign bus.add_b     = b_q;
   assign bus.out_sum   = sum_q;
   assign bus.out_valid = valid_q;
   assign busy          = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         valid_q <= valid_d;
      end
   end

   // Accept is applied after the case so a HOLD handshake can reload with no IDLE bubble
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      valid_d = valid_q;
      case (state)
         IDLE: ;
         SETTLE: begin
            if (capture) begin
               sum_d   = bus.add_sum;
               valid_d = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         a_d     = bus.in_a;
         b_d     = bus.in_b;
         cnt_d   = CNT_LOAD;
         state_d = SETTLE;
      end
   end

`ifdef ADDER_CHECK_EN
   logic           err_q;
   logic [WIDTH:0] ref_sum;

   assign ref_sum = {1'b0, a_q} + {1'b0, b_q};
   assign err     = err_q;

   // Sticky until reset; the captured sum is never altered by the check
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (capture && (bus.add_sum != ref_sum)) begin
         err_q <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_stage_ctrl.sv
// Bench: SETTLE_CYCLES=2 and =1 instances share stimulus; a timing-level
// reference model (age since accept) predicts every observable output.
module tb_adder_stage_ctrl;
   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          stuck = 1'b0;
   logic          busy0, busy1, err0, err1;

   int errors = 0;
   int checks = 0;

   adder_stage_ctrl_if #(.WIDTH(W)) bif0 ();
   adder_stage_ctrl_if #(.WIDTH(W)) bif1 ();

   adder_stage_ctrl #(.WIDTH(W), .SETTLE_CYCLES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bif0), .busy(busy0), .err(err0));
   adder_stage_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bif1), .busy(busy1), .err(err1));

   always #5 clk = ~clk;

   assign bif0.in_valid  = in_valid;
   assign bif1.in_valid  = in_valid;
   assign bif0.in_a      = in_a;
   assign bif1.in_a      = in_a;
   assign bif0.in_b      = in_b;
   assign bif1.in_b      = in_b;
   assign bif0.out_ready = out_ready;
   assign bif1.out_ready = out_ready;
   // Zero-delay adder stand-in; stuck forces SUM[0] low
   assign bif0.add_sum = ({1'b0, bif0.add_a} + {1'b0, bif0.add_b}) & ~{32'd0, stuck};
   assign bif1.add_sum = ({1'b0, bif1.add_a} + {1'b0, bif1.add_b}) & ~{32'd0, stuck};

`ifdef ADDER_CHECK_EN
   localparam bit CHECK_ON = 1'b1;
`else
   localparam bit CHECK_ON = 1'b0;
`endif

   // reference model state, per instance
   int          settle [2] = '{2, 1};
   bit          have   [2];
   int          age    [2];
   logic [31:0] ea     [2];
   logic [31:0] eb     [2];
   logic [32:0] cap    [2];
   bit          eerr   [2];

   function automatic logic [32:0] true_sum(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'(a) + longint'(b);
      return s[32:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic dut_outs(input int i, output logic ir, output logic ov, output logic bz,
                           output logic er, output logic [32:0] sm,
                           output logic [31:0] aa, output logic [31:0] ab);
      if (i == 0) begin
         ir = bif0.in_ready; ov = bif0.out_valid; bz = busy0; er = err0;
         sm = bif0.out_sum;  aa = bif0.add_a;     ab = bif0.add_b;
      end else begin
         ir = bif1.in_ready; ov = bif1.out_valid; bz = busy1; er = err1;
         sm = bif1.out_sum;  aa = bif1.add_a;     ab = bif1.add_b;
      end
   endtask

   task automatic model_check();
      logic ir, ov, bz, er;
      logic [32:0] sm;
      logic [31:0] aa, ab;
      bit e_ov, e_ir;
      for (int i = 0; i < 2; i++) begin
         dut_outs(i, ir, ov, bz, er, sm, aa, ab);
         e_ov = have[i] && (age[i] >= settle[i]);
         e_ir = !have[i] || (e_ov && out_ready);
         chk($sformatf("s%0d_in_ready", settle[i]), 64'(ir), 64'(e_ir));
         chk($sformatf("s%0d_out_valid", settle[i]), 64'(ov), 64'(e_ov));
         chk($sformatf("s%0d_busy", settle[i]), 64'(bz), 64'(have[i]));
         chk($sformatf("s%0d_err", settle[i]), 64'(er), 64'(eerr[i]));
         if (e_ov) chk($sformatf("s%0d_out_sum", settle[i]), 64'(sm), 64'(cap[i]));
         if (have[i]) begin
            chk($sformatf("s%0d_add_a", settle[i]), 64'(aa), 64'(ea[i]));
            chk($sformatf("s%0d_add_b", settle[i]), 64'(ab), 64'(eb[i]));
         end
      end
   endtask

   // Advance the model across one rising edge using the inputs present at that edge
   task automatic model_update();
      bit e_ov, e_ir;
      logic [32:0] good, seen;
      for (int i = 0; i < 2; i++) begin
         e_ov = have[i] && (age[i] >= settle[i]);
         e_ir = !have[i] || (e_ov && out_ready);
         if (have[i] && (age[i] == settle[i] - 1)) begin
            good = true_sum(ea[i], eb[i]);
            seen = stuck ? (good & ~33'd1) : good;
            cap[i] = seen;
            if (CHECK_ON && (seen != good)) eerr[i] = 1'b1;
         end
         if (e_ov && out_ready) have[i] = 1'b0;
         if (in_valid && e_ir) begin
            have[i] = 1'b1;
            age[i]  = 0;
            ea[i]   = in_a;
            eb[i]   = in_b;
         end else if (have[i]) begin
            age[i]++;
         end
      end
   endtask

   task automatic cycle(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         model_check();
         @(posedge clk);
         model_update();
         #1;
      end
   endtask

   task automatic do_reset();
      logic ir, ov, bz, er;
      logic [32:0] sm;
      logic [31:0] aa, ab;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         dut_outs(i, ir, ov, bz, er, sm, aa, ab);
         chk($sformatf("s%0d_rst_out_valid", settle[i]), 64'(ov), 64'(0));
         chk($sformatf("s%0d_rst_busy", settle[i]), 64'(bz), 64'(0));
         chk($sformatf("s%0d_rst_in_ready", settle[i]), 64'(ir), 64'(1));
         chk($sformatf("s%0d_rst_out_sum", settle[i]), 64'(sm), 64'(0));
         chk($sformatf("s%0d_rst_add_a", settle[i]), 64'(aa), 64'(0));
         chk($sformatf("s%0d_rst_add_b", settle[i]), 64'(ab), 64'(0));
         chk($sformatf("s%0d_rst_err", settle[i]), 64'(er), 64'(0));
         have[i] = 1'b0;
         age[i]  = 0;
         eerr[i] = 1'b0;
      end
      #2;
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   initial begin
      do_reset();
      cycle(2);

      // reset one cycle after accept: transaction must vanish
      out_ready = 1'b1;
      send(32'h1234_5678, 32'h1234_5678);
      do_reset();
      cycle(6);

      // signed-overflow boundary, no carry out
      send(32'h7FFF_FFFF, 32'h0000_0001);
      cycle(5);

      // held result under backpressure, second pair pending
      out_ready = 1'b0;
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      in_a = 32'd1;
      in_b = 32'd1;
      in_valid = 1'b1;
      cycle(7);
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle(5);

      // back-to-back streaming
      in_a = 32'd1;
      in_b = 32'd1;
      in_valid = 1'b1;
      cycle();
      in_a = 32'hFFFF_FFFF;
      in_b = 32'd1;
      cycle(4);
      in_valid = 1'b0;
      cycle(5);

      // double-MSB carry out
      send(32'h8000_0000, 32'h8000_0000);
      cycle(4);

      // faulty adder bit, then a correct add
      stuck = 1'b1;
      send(32'd0, 32'd1);
      cycle(4);
      stuck = 1'b0;
      send(32'hF0F0_F0F0, 32'h0F0F_0F0F);
      cycle(4);

      do_reset();
      cycle();

      // randomized traffic
      for (int r = 0; r < 400; r++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         case ($urandom % 4)
            0:       in_a = 32'hFFFF_FFFF;
            1:       in_a = 32'h0;
            default: in_a = $urandom;
         endcase
         in_b = (($urandom % 4) == 0) ? 32'hFFFF_FFFF : $urandom;
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycle(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adder_stage_ctrl.md
# adder_stage_ctrl

Sequencing stage placed directly upstream of the 32-bit carry-skip adder (`CSkipA32`). It accepts operand pairs over a valid/ready handshake and drives them, registered and stable, onto the adder's combinational A/B inputs. It waits a fixed settle window, then captures the 33-bit SUM into an output register. The result is presented downstream over a second valid/ready handshake.

## Interface
- `WIDTH`, 32: operand width; result is WIDTH+1 bits.
- `SETTLE_CYCLES`, 2: clock cycles allowed for the combinational adder to settle; legal range 1..15.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  stage can accept an operand pair.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `add_a`  out  WIDTH  registered operand A to the adder's A port.
- `add_b`  out  WIDTH  registered operand B to the adder's B port.
- `add_sum`  in  WIDTH+1  adder's SUM output.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  WIDTH+1  captured result.
- `busy`  out  1  high whenever state is not IDLE.
- `err`  out  1  sticky adder-mismatch flag; see Configuration.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - SETTLE: counter runs.
  - HOLD: `out_valid`=1.
- `in_ready` is combinational: (state==IDLE) | (state==HOLD & `out_ready`).
- Accept occurs when `in_valid & in_ready` at a rising edge. On accept:
  - `add_a`/`add_b` load `in_a`/`in_b`.
  - Counter loads SETTLE_CYCLES-1.
  - State goes to SETTLE.
- SETTLE:
  - Counter decrements each cycle while nonzero.
  - When counter==0, `out_sum` loads `add_sum`, `out_valid` sets, and state goes to HOLD.
- HOLD:
  - `out_sum` and `out_valid` stay stable until `out_valid & out_ready`.
  - On that handshake with no simultaneous accept, `out_valid` clears and state goes to IDLE.
  - On that handshake with a simultaneous accept, `out_valid` clears, new operands load, and state goes to SETTLE (no IDLE bubble).
- `add_a`/`add_b` change only on accept and hold their value through SETTLE and HOLD.
- No arithmetic is done in this block. `out_sum` is exactly the captured WIDTH+1-bit `add_sum`; the carry-out is bit WIDTH.
- Counter width is 4 bits.
- `in_valid` while `in_ready`=0 is ignored; no buffering, no loss of the held result.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE.
  - `add_a`, `add_b`, `out_sum` = 0.
  - `out_valid`, `busy`, `err` = 0.
  - Counter = 0.
  - `in_ready` reads 1 after release.
- Reset asserted mid-SETTLE or mid-HOLD aborts the transaction; the result is discarded and never presented.
- Latency: accept at edge T; `add_a`/`add_b` valid after T; `out_sum` captured and `out_valid`=1 after edge T+SETTLE_CYCLES.
- Throughput with `out_ready` held high: one result every SETTLE_CYCLES+1 cycles.
- SETTLE_CYCLES=1: capture happens at the first edge after accept.

## Configuration
- `ADDER_CHECK_EN` defined:
  - At the capture edge, `add_sum` is compared against {1'b0,`add_a`}+{1'b0,`add_b`} computed behaviourally.
  - A mismatch sets `err`, which stays sticky until reset.
  - `out_sum` still takes `add_sum` unchanged.
- `ADDER_CHECK_EN` undefined: `err` is tied 0 and no behavioural adder is elaborated.

## Test plan
- Reset during SETTLE, with A=12345678, B=12345678, `rst_n` pulsed low one cycle after accept:
  - state IDLE, `out_valid`=0 and `busy`=0 immediately;
  - no result ever emitted.
- SETTLE_CYCLES=2, A=7FFFFFFF, B=00000001, `out_ready`=1:
  - `out_valid` rises after edge T+2;
  - `out_sum`=0_80000000.
- A=FFFFFFFF, B=FFFFFFFF, `out_ready` low for 5 cycles, `in_valid` held high with A=1, B=1:
  - `out_sum`=1_FFFFFFFE, stable;
  - `in_ready`=0 and second pair not accepted until the handshake.
- Back-to-back, `in_valid` and `out_ready` held high, pairs (1,1) then (FFFFFFFF,1):
  - second pair accepted on the same edge as the first output handshake;
  - results 0_00000002 then 1_00000000, spaced SETTLE_CYCLES+1 cycles.
- `ADDER_CHECK_EN` defined, adder model with `add_sum`[0] stuck at 0, A=0, B=1:
  - `err`=1 after the capture edge;
  - `err` stays 1 through a subsequent correct add of F0F0F0F0+0F0F0F0F.
- SETTLE_CYCLES=1, A=80000000, B=80000000:
  - `out_valid` after edge T+1;
  - `out_sum`=1_00000000.
